// File: rtl/sync_fifo_reg_if.sv
// sync_fifo_reg_if: producer/consumer bundle of the register FIFO.
// master drives requests and data; slave is the FIFO itself.
interface sync_fifo_reg_if #(
  parameter int DW      = 32,
  parameter int LEN_LOG = 2
);
  logic               enq;
  logic [DW-1:0]      din;
  logic               deq;
  logic [DW-1:0]      dot;
  logic               dvalid;
  logic               full;
  logic               empty;
  logic               afull;
  logic               aempty;
  logic [LEN_LOG:0]   cnt;
  logic               clr_err;
  logic               ovf;
  logic               udf;

  modport master (
    output enq, din, deq, clr_err,
    input  dot, dvalid, full, empty,
    input  afull, aempty, cnt, ovf, udf
  );

  modport slave (
    input  enq, din, deq, clr_err,
    output dot, dvalid, full, empty,
    output afull, aempty, cnt, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_reg.sv
// sync_fifo_reg: single-clock register-array FIFO with level flags,
// occupancy and sticky overflow/underflow, show-ahead or registered read.
module sync_fifo_reg #(
  parameter int DW      = 32,
  parameter int LEN_LOG = 2,
  parameter int AF_TH   = (1 << LEN_LOG) - 1,
  parameter int AE_TH   = 1,
  parameter int FWFT    = 1
) (
  input logic            CLK,
  input logic            RST,
  sync_fifo_reg_if.slave f
);
  localparam int LEN = 1 << LEN_LOG;
  localparam logic [LEN_LOG:0] LEN_C = (LEN_LOG+1)'(LEN);
  localparam logic [LEN_LOG:0] AF_C  = (LEN_LOG+1)'(AF_TH);
  localparam logic [LEN_LOG:0] AE_C  = (LEN_LOG+1)'(AE_TH);

  if (LEN_LOG < 1 || AF_TH < 1 || AF_TH > LEN ||
      AE_TH < 0 || AE_TH > LEN - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_bad_param
    $error("sync_fifo_reg: illegal parameter set");
  end

  logic [DW-1:0]      mem [LEN];
  logic [LEN_LOG-1:0] wadr;
  logic [LEN_LOG-1:0] radr;
  logic [LEN_LOG:0]   cnt_q;
  logic [LEN_LOG:0]   cnt_d;
  logic               full_q;
  logic               empty_q;
  logic               afull_q;
  logic               aempty_q;
  logic               ovf_q;
  logic               udf_q;
  logic               enq_acc;
  logic               deq_acc;

  // a deq on a full FIFO frees the slot the same cycle
  always_comb begin
    deq_acc = f.deq & ~empty_q;
    enq_acc = f.enq & (~full_q | deq_acc);
    cnt_d   = cnt_q;
    unique case ({enq_acc, deq_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wadr     <= '0;
      radr     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (enq_acc) wadr <= wadr + 1'b1;
      if (deq_acc) radr <= radr + 1'b1;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == LEN_C);
      empty_q  <= (cnt_d == '0);
      afull_q  <= (cnt_d >= AF_C);
      aempty_q <= (cnt_d <= AE_C);
      if (f.enq & ~enq_acc) ovf_q <= 1'b1;
      else if (f.clr_err)   ovf_q <= 1'b0;
      if (f.deq & empty_q)  udf_q <= 1'b1;
      else if (f.clr_err)   udf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_acc & ~RST) mem[wadr] <= f.din;
  end

  if (FWFT != 0) begin : g_fwft
    assign f.dot    = mem[radr];
    assign f.dvalid = ~empty_q;
  end else begin : g_reg
    logic [DW-1:0] dot_q;
    logic          dvalid_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        dot_q    <= '0;
        dvalid_q <= 1'b0;
      end else if (deq_acc) begin
        dot_q    <= mem[radr];
        dvalid_q <= 1'b1;
      end else begin
        dvalid_q <= 1'b0;
      end
    end

    assign f.dot    = dot_q;
    assign f.dvalid = dvalid_q;
  end

  assign f.cnt    = cnt_q;
  assign f.full   = full_q;
  assign f.empty  = empty_q;
  assign f.afull  = afull_q;
  assign f.aempty = aempty_q;
  assign f.ovf    = ovf_q;
  assign f.udf    = udf_q;
endmodule

// File: tb/tb_sync_fifo_reg.sv
// tb_sync_fifo_reg: directed bench for a show-ahead and a
// registered-output instance sharing clock and reset.
module tb_sync_fifo_reg;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  sync_fifo_reg_if #(.DW(8), .LEN_LOG(2)) if1 ();
  sync_fifo_reg_if #(.DW(8), .LEN_LOG(2)) if0 ();

  sync_fifo_reg #(.DW(8), .LEN_LOG(2), .FWFT(1)) u1 (
    .CLK (CLK),
    .RST (RST),
    .f   (if1.slave)
  );

  sync_fifo_reg #(.DW(8), .LEN_LOG(2), .FWFT(0)) u0 (
    .CLK (CLK),
    .RST (RST),
    .f   (if0.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] fill_d [4];
  logic [7:0] drn_d  [4];

  initial begin
    fill_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    drn_d  = '{8'h22, 8'h33, 8'h44, 8'h66};
    if1.enq = 0; if1.din = 0; if1.deq = 0; if1.clr_err = 0;
    if0.enq = 0; if0.din = 0; if0.deq = 0; if0.clr_err = 0;

    tick();
    RST = 0;
    chk("rst_cnt",    32'(if1.cnt),    0);
    chk("rst_empty",  32'(if1.empty),  1);
    chk("rst_full",   32'(if1.full),   0);
    chk("rst_afull",  32'(if1.afull),  0);
    chk("rst_aempty", 32'(if1.aempty), 1);
    chk("rst_ovf",    32'(if1.ovf),    0);
    chk("rst_udf",    32'(if1.udf),    0);
    chk("rst_dvalid0", 32'(if0.dvalid), 0);
    chk("rst_dot0",   32'(if0.dot),    0);

    for (int i = 0; i < 4; i++) begin
      if1.enq = 1; if1.din = fill_d[i];
      tick();
      chk("fill_cnt",    32'(if1.cnt),    32'(i + 1));
      chk("fill_full",   32'(if1.full),   32'(i == 3));
      chk("fill_afull",  32'(if1.afull),  32'(i >= 2));
      chk("fill_aempty", 32'(if1.aempty), 32'(i == 0));
    end

    if1.din = 8'h55;
    tick();
    chk("ovf_set",  32'(if1.ovf),  1);
    chk("ovf_cnt",  32'(if1.cnt),  4);
    chk("ovf_full", 32'(if1.full), 1);
    if1.enq = 0; if1.clr_err = 1;
    tick();
    chk("ovf_clr", 32'(if1.ovf), 0);
    if1.clr_err = 0;

    chk("pass_head", 32'(if1.dot), 32'h11);
    if1.enq = 1; if1.din = 8'h66; if1.deq = 1;
    tick();
    chk("pass_cnt",  32'(if1.cnt),  4);
    chk("pass_ovf",  32'(if1.ovf),  0);
    chk("pass_full", 32'(if1.full), 1);
    if1.enq = 0;

    for (int k = 0; k < 4; k++) begin
      chk("drain_dot", 32'(if1.dot), 32'(drn_d[k]));
      tick();
      chk("drain_cnt",    32'(if1.cnt),    32'(3 - k));
      chk("drain_empty",  32'(if1.empty),  32'(k == 3));
      chk("drain_aempty", 32'(if1.aempty), 32'(k >= 2));
    end
    chk("drain_dvalid", 32'(if1.dvalid), 0);

    tick();
    chk("udf_set", 32'(if1.udf), 1);
    chk("udf_cnt", 32'(if1.cnt), 0);
    if1.enq = 1; if1.din = 8'hA5;
    tick();
    if1.enq = 0; if1.deq = 0;
    chk("sim_cnt",   32'(if1.cnt),   1);
    chk("sim_udf",   32'(if1.udf),   1);
    chk("sim_empty", 32'(if1.empty), 0);
    chk("sim_dot",   32'(if1.dot),   32'hA5);
    if1.deq = 1;
    tick();
    chk("sim_drain", 32'(if1.cnt), 0);
    if1.clr_err = 1;
    tick();
    chk("udf_event_wins", 32'(if1.udf), 1);
    if1.deq = 0;
    tick();
    chk("udf_clr", 32'(if1.udf), 0);
    if1.clr_err = 0;

    for (int i = 0; i < 10; i++) begin
      if0.enq = 1; if0.din = 8'(i); if0.deq = 0;
      tick();
      chk("wrap_idle_dv", 32'(if0.dvalid), 0);
      chk("wrap_cnt1",    32'(if0.cnt),    1);
      if0.enq = 0; if0.deq = 1;
      tick();
      chk("wrap_dv",  32'(if0.dvalid), 1);
      chk("wrap_dot", 32'(if0.dot),    32'(i));
    end
    if0.deq = 0;
    tick();
    chk("wrap_dv_drop",  32'(if0.dvalid), 0);
    chk("wrap_dot_hold", 32'(if0.dot),    9);

    for (int i = 1; i <= 2; i++) begin
      if1.enq = 1; if1.din = 8'(i);
      if0.enq = 1; if0.din = 8'(i);
      tick();
    end
    chk("pre_rst_cnt", 32'(if0.cnt), 2);
    RST = 1;
    if1.din = 8'h99; if1.deq = 1;
    if0.din = 8'h99; if0.deq = 1;
    tick();
    RST = 0;
    if1.enq = 0; if1.deq = 0;
    if0.enq = 0; if0.deq = 0;
    chk("mrst_cnt",    32'(if1.cnt),    0);
    chk("mrst_empty",  32'(if1.empty),  1);
    chk("mrst_ovf",    32'(if1.ovf),    0);
    chk("mrst_udf",    32'(if1.udf),    0);
    chk("mrst_cnt0",   32'(if0.cnt),    0);
    chk("mrst_dvalid", 32'(if0.dvalid), 0);

    if1.enq = 1; if1.din = 8'h7E;
    if0.enq = 1; if0.din = 8'h7E;
    tick();
    if1.enq = 0; if0.enq = 0;
    chk("post_rst_dot1", 32'(if1.dot), 32'h7E);
    chk("post_rst_cnt1", 32'(if1.cnt), 1);
    if0.deq = 1;
    tick();
    if0.deq = 0;
    chk("post_rst_dv0",  32'(if0.dvalid), 1);
    chk("post_rst_dot0", 32'(if0.dot),    32'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_reg.md
Name: sync_fifo_reg

Overview:
Single-clock, register-array FIFO with full/empty, almost-full/almost-empty and occupancy outputs, plus sticky overflow/underflow error flags. It is the flagged, parametrised successor to our free-running register DCFIFO and is used wherever producer and consumer share one clock domain. FWFT mode selects a show-ahead combinational output or a registered read output.

Parameters:
DW, 32, data width in bits.
LEN_LOG, 2, log2 of depth; legal range is 1 or more.
LEN, 1<<LEN_LOG, depth in entries; derived, do not override.
AF_TH, LEN-1, afull asserts when cnt >= AF_TH; legal range 1..LEN.
AE_TH, 1, aempty asserts when cnt <= AE_TH; legal range 0..LEN-1.
FWFT, 1, 1 = show-ahead output; 0 = registered output with 1-cycle read latency.

Ports:
CLK  in  1  clock; all logic on posedge.
RST  in  1  synchronous reset, active-high.
enq  in  1  write request.
din  in  DW  write data, sampled with enq.
deq  in  1  read request.
dot  out  DW  read data.
dvalid  out  1  dot is valid.
full  out  1  cnt == LEN.
empty  out  1  cnt == 0.
afull  out  1  cnt >= AF_TH.
aempty  out  1  cnt <= AE_TH.
cnt  out  LEN_LOG+1  occupancy, 0..LEN.
clr_err  in  1  clears ovf and udf.
ovf  out  1  sticky: an enq was dropped.
udf  out  1  sticky: a deq was issued while empty.

Behaviour:
- Reset, when RST=1 at a posedge:
  - wadr=0, radr=0, cnt=0.
  - empty=1, full=0, afull=0, aempty=1.
  - ovf=0, udf=0, dvalid=0 (FWFT=0).
  - In FWFT=0, dot=0.
  - The memory array is not reset.
  - RST overrides every other input in the same cycle. Any in-flight read in FWFT=0 is cancelled, so dvalid is 0 in the next cycle.
- Acceptance:
  - deq_acc = deq & ~empty.
  - enq_acc = enq & (~full | deq_acc). When full, a simultaneous accepted deq frees the slot in the same cycle, so the write is accepted.
- Pointers: wadr and radr are LEN_LOG bits wide and advance by 1 on enq_acc and deq_acc respectively. They wrap modulo LEN naturally.
- Write: on enq_acc, mem[wadr] <= din.
- cnt update:
  - +1 on enq_acc only.
  - -1 on deq_acc only.
  - Unchanged when both or neither are accepted.
- Flags: full, empty, afull and aempty are registered. They are computed from next-cycle cnt, so they agree with cnt in the same cycle with no lag.
- Empty with enq & deq together: deq is rejected (udf sets) and enq is accepted. No bypass from din to dot.
- FWFT=1:
  - dot = mem[radr], combinational.
  - dvalid = ~empty.
  - A written word appears on dot one cycle after the enq cycle.
- FWFT=0:
  - On deq_acc, dot <= mem[radr] and dvalid <= 1.
  - Otherwise dvalid <= 0 and dot holds its last value.
  - Read latency is 1 cycle.
- Errors:
  - ovf <= 1 when enq & ~enq_acc.
  - udf <= 1 when deq & empty.
  - clr_err clears both. If a new error event occurs in the same cycle, the event wins.
  - Errors never alter FIFO state: dropped writes are discarded and rejected reads do not move radr.
- Elaboration: parameter values outside the legal ranges stop elaboration via a generate-time check.

Test Plan:
- Fill/drain (DW=8, LEN_LOG=2, FWFT=1): after RST, enq 0x11,0x22,0x33,0x44 on consecutive cycles, then deq 4 cycles.
  - During fill: cnt goes 1,2,3,4; full=1 after the 4th write; afull=1 from cnt=3.
  - During drain: dot reads 0x11,0x22,0x33,0x44 in order; empty=1 after the last deq; aempty=1 at cnt<=1.
- Overflow: with the FIFO full, enq 0x55 alone.
  - Response: ovf=1, cnt stays 4, next read sequence unchanged.
  - Then clr_err: ovf=0.
- Full pass-through: with the FIFO full, enq 0x66 and deq in the same cycle.
  - Response: both accepted, cnt stays 4, ovf=0, 0x66 is read last.
- Wrap and latency (FWFT=0): run 10 interleaved enq/deq pairs with data 0..9.
  - Response: dvalid pulses exactly one cycle after each accepted deq; dot equals the data in order; pointers wrap past 3 with no corruption.
- Underflow and simultaneous on empty: from empty, deq alone, then enq 0xA5 and deq together.
  - Response: udf=1, cnt ends at 1, and the next deq returns 0xA5.
- Mid-operation reset: at cnt=2, assert RST for one cycle together with enq and deq.
  - Response: cnt=0, empty=1, dvalid=0, ovf=0, udf=0.
  - The next enq 0x7E is the first word read out.
